// File: rtl/memory_stage_lsu.sv
// Memory-stage load/store unit: turns M-stage control into word-aligned req/ack
// data-memory accesses, aligns store data/byte enables and extends load data.
module memory_stage_lsu #(
  parameter int         ADDR_W  = 13,
  parameter int         TIMEOUT = 16,
  parameter logic [1:0] WB_MEM  = 2'b01
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              mem_wrenM,
  input  logic [1:0]        wb_selM,
  input  logic [2:0]        ld_selM,
  input  logic [3:0]        byte_enM,
  input  logic [31:0]       alu_dataM,
  input  logic [31:0]       forward2outM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       ld_dataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              mem_errM
);

  localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  // Access size comes from the store mask for stores, else from the load type.
  function automatic logic misaligned_f(input logic wr, input logic [2:0] sel,
                                        input logic [3:0] be, input logic [1:0] a);
    logic half_v;
    logic word_v;
    if (wr) begin
      half_v = (be == 4'b0011);
      word_v = (be == 4'b1111);
    end else begin
      half_v = (sel[1:0] == 2'b01);
      word_v = (sel[1:0] == 2'b10);
    end
    return (half_v & a[0]) | (word_v & (a != 2'b00));
  endfunction

  function automatic logic [31:0] extend_f(input logic [31:0] d, input logic [2:0] sel);
    logic [31:0] r;
    case (sel)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [TCNT_W-1:0] tcnt_r;
  logic [1:0]        a_r;
  logic [2:0]        ld_sel_r;
  logic [1:0]        a_s;
  logic              acc_s;
  logic              mis_s;
  logic              issue_s;
  logic              ack_s;
  logic              tmo_s;
  logic              unused_s;

  assign a_s      = alu_dataM[1:0];
  assign acc_s    = mem_wrenM | (wb_selM == WB_MEM);
  assign mis_s    = misaligned_f(mem_wrenM, ld_selM, byte_enM, a_s);
  assign issue_s  = (state_r == IDLE) & acc_s & ~mis_s;
  assign ack_s    = (state_r == REQ) & dmem_ack;
  assign tmo_s    = (state_r == REQ) & ~dmem_ack & (tcnt_r == TCNT_LAST);
  assign unused_s = ^alu_dataM[31:ADDR_W];

  // State register
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (issue_s) state_nxt_s = REQ; else state_nxt_s = IDLE;
      REQ:     if (ack_s | tmo_s) state_nxt_s = DONE; else state_nxt_s = REQ;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pipeline stall and misalignment flags (combinational, current cycle)
  always_comb begin
    stallM    = 1'b0;
    misalignM = 1'b0;
    case (state_r)
      IDLE: begin
        stallM    = acc_s & ~mis_s;
        misalignM = acc_s & mis_s;
      end
      REQ:     stallM = 1'b1;
      default: stallM = 1'b0;
    endcase
  end

  // Bus request registers, timeout counter and load result capture
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= {(ADDR_W-2){1'b0}};
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'd0;
      ld_dataM   <= 32'd0;
      mem_errM   <= 1'b0;
      tcnt_r     <= {TCNT_W{1'b0}};
      a_r        <= 2'b00;
      ld_sel_r   <= 3'b000;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_wrenM;
            dmem_addr  <= alu_dataM[ADDR_W-1:2];
            dmem_be    <= mem_wrenM ? (byte_enM << a_s) : 4'b0000;
            dmem_wdata <= forward2outM << {a_s, 3'b000};
            a_r        <= a_s;
            ld_sel_r   <= ld_selM;
          end
        end
        REQ: begin
          // An ack on the final counted cycle wins over the timeout.
          if (ack_s) begin
            dmem_req <= 1'b0;
            tcnt_r   <= {TCNT_W{1'b0}};
            ld_dataM <= dmem_we ? 32'd0 : extend_f(dmem_rdata >> {a_r, 3'b000}, ld_sel_r);
          end else if (tmo_s) begin
            dmem_req <= 1'b0;
            tcnt_r   <= {TCNT_W{1'b0}};
            ld_dataM <= 32'd0;
            mem_errM <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end
        DONE: begin
          mem_errM <= 1'b0;
          tcnt_r   <= {TCNT_W{1'b0}};
        end
        default: begin
          dmem_req <= 1'b0;
          mem_errM <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Randomised and directed bench for memory_stage_lsu against a behavioural
// per-access model (sizes, shifts and sign extension by plain arithmetic).
module tb_memory_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        aclr;
  logic        mem_wrenM;
  logic [1:0]  wb_selM;
  logic [2:0]  ld_selM;
  logic [3:0]  byte_enM;
  logic [31:0] alu_dataM;
  logic [31:0] forward2outM;
  logic        dmem_req;
  logic        dmem_we;
  logic [10:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ld_dataM;
  logic        stallM;
  logic        misalignM;
  logic        mem_errM;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_stage_lsu #(.ADDR_W(13), .TIMEOUT(TIMEOUT), .WB_MEM(2'b01)) dut (
    .clk(clk), .aclr(aclr), .mem_wrenM(mem_wrenM), .wb_selM(wb_selM),
    .ld_selM(ld_selM), .byte_enM(byte_enM), .alu_dataM(alu_dataM),
    .forward2outM(forward2outM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ld_dataM(ld_dataM),
    .stallM(stallM), .misalignM(misalignM), .mem_errM(mem_errM)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    mem_wrenM    = 1'b0;
    wb_selM      = 2'b00;
    ld_selM      = 3'($urandom_range(0, 7));
    byte_enM     = 4'($urandom_range(0, 15));
    alu_dataM    = $urandom;
    forward2outM = $urandom;
  endtask

  // One complete access; ack_at is the REQ cycle index carrying ack (>= TIMEOUT: never).
  task automatic do_access(input string name, input bit wr, input bit ld, input logic [2:0] ldsel,
                           input logic [3:0] bemask, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_at, input logic [31:0] rdata);
    int          size, a, n_req, stall_cnt, b, h;
    bit          mis, timed_out;
    logic [31:0] exp_ld, exp_wd, shifted;
    logic [3:0]  exp_be;
    logic [10:0] exp_addr;
    logic [17:0] exp_ctl, got_ctl;
    a = int'(addr[1:0]);
    if (wr) size = (bemask == 4'b1111) ? 4 : (bemask == 4'b0011) ? 2 : 1;
    else    size = (ldsel[1:0] == 2'b10) ? 4 : (ldsel[1:0] == 2'b01) ? 2 : 1;
    mis       = (a % size) != 0;
    exp_be    = wr ? 4'((int'(bemask) << a) & 15) : 4'b0000;
    exp_wd    = data << (8 * a);
    exp_addr  = 11'(addr >> 2);
    timed_out = (ack_at >= TIMEOUT);
    n_req     = timed_out ? TIMEOUT : ack_at + 1;
    shifted   = rdata >> (8 * a);
    b         = int'(shifted % 32'd256);
    h         = int'(shifted % 32'd65536);
    case (ldsel)
      3'b000:  exp_ld = (b >= 128) ? 32'(b - 256) : 32'(b);
      3'b001:  exp_ld = (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b100:  exp_ld = 32'(b);
      3'b101:  exp_ld = 32'(h);
      default: exp_ld = shifted;
    endcase
    if (wr || timed_out) exp_ld = 32'd0;

    mem_wrenM = wr; wb_selM = ld ? 2'b01 : 2'b00; ld_selM = ldsel;
    byte_enM = bemask; alu_dataM = addr; forward2outM = data;
    #1;
    tests_run++;
    if ({misalignM, stallM} !== {mis, !mis}) begin
      tests_failed++;
      $display("FAIL %s detect: misalign/stall got %b expected %b", name, {misalignM, stallM}, {mis, !mis});
    end
    if (mis) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        tests_run++;
        if ({dmem_req, stallM} !== 2'b00) begin
          tests_failed++;
          $display("FAIL %s no_req cycle %0d: req/stall got %b expected 00", name, i, {dmem_req, stallM});
        end
      end
      idle_inputs();
      return;
    end

    stall_cnt = 1;
    exp_ctl   = {1'b1, 1'b1, wr, exp_addr, exp_be};
    for (int k = 0; k < TIMEOUT; k++) begin
      @(posedge clk); #1;
      got_ctl = {dmem_req, stallM, dmem_we, dmem_addr, dmem_be};
      tests_run++;
      if (got_ctl !== exp_ctl) begin
        tests_failed++;
        $display("FAIL %s req cycle %0d: req/stall/we/addr/be got %h expected %h", name, k, got_ctl, exp_ctl);
      end
      if (wr) begin
        tests_run++;
        if (dmem_wdata !== exp_wd) begin
          tests_failed++;
          $display("FAIL %s wdata cycle %0d: got %h expected %h", name, k, dmem_wdata, exp_wd);
        end
      end
      stall_cnt += int'(stallM);
      dmem_ack   = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : $urandom;
      if (k == ack_at) break;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    tests_run++;
    if ({dmem_req, stallM, mem_errM} !== {1'b0, 1'b0, timed_out}) begin
      tests_failed++;
      $display("FAIL %s done: req/stall/err got %b expected %b", name, {dmem_req, stallM, mem_errM}, {2'b00, timed_out});
    end
    tests_run++;
    if (ld_dataM !== exp_ld) begin
      tests_failed++;
      $display("FAIL %s ld_data: got %h expected %h", name, ld_dataM, exp_ld);
    end
    tests_run++;
    if (stall_cnt != n_req + 1) begin
      tests_failed++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, n_req + 1);
    end
    @(posedge clk); #1;
    idle_inputs(); #1;
    tests_run++;
    if ({dmem_req, stallM, mem_errM, ld_dataM} !== {3'b000, exp_ld}) begin
      tests_failed++;
      $display("FAIL %s after_done: req/stall/err/ld got %h expected %h", name,
               {dmem_req, stallM, mem_errM, ld_dataM}, {3'b000, exp_ld});
    end
  endtask

  task automatic test_reset();
    idle_inputs(); dmem_ack = 1'b0; dmem_rdata = 32'd0;
    aclr = 1'b1; #3 aclr = 1'b0; #1;
    tests_run++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ld_dataM, mem_errM, stallM, misalignM} !== 84'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0",
               {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ld_dataM, mem_errM, stallM, misalignM});
    end
    @(posedge clk); #1; aclr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_examples();
    do_access("sw_104", 1'b1, 1'b0, 3'b010, 4'b1111, 32'h104, 32'hDEADBEEF, 0, 32'h0);
    do_access("sb_013", 1'b1, 1'b0, 3'b000, 4'b0001, 32'h013, 32'h000000A5, 3, 32'h0);
    do_access("lb_002", 1'b0, 1'b1, 3'b000, 4'b0000, 32'h002, 32'h0, 1, 32'h00800000);
    do_access("lbu_002", 1'b0, 1'b1, 3'b100, 4'b0000, 32'h002, 32'h0, 0, 32'h00800000);
    do_access("lh_001_mis", 1'b0, 1'b1, 3'b001, 4'b0000, 32'h001, 32'h0, 0, 32'h0);
  endtask

  task automatic test_extension();
    do_access("lh_002", 1'b0, 1'b1, 3'b001, 4'b0000, 32'h1002, 32'h0, 2, 32'h9ABC1234);
    do_access("lhu_002", 1'b0, 1'b1, 3'b101, 4'b0000, 32'h1002, 32'h0, 0, 32'h9ABC1234);
    do_access("ld_undef", 1'b0, 1'b1, 3'b011, 4'b0000, 32'h040, 32'h0, 1, 32'hCAFEF00D);
    do_access("st_as_ld", 1'b1, 1'b1, 3'b000, 4'b0011, 32'h022, 32'h0000BEEF, 0, 32'hFFFFFFFF);
    do_access("sw_mis", 1'b1, 1'b0, 3'b010, 4'b1111, 32'h102, 32'h11223344, 0, 32'h0);
    do_access("sh_mis", 1'b1, 1'b0, 3'b001, 4'b0011, 32'h003, 32'h11223344, 0, 32'h0);
  endtask

  task automatic test_timeout();
    do_access("lw_timeout", 1'b0, 1'b1, 3'b010, 4'b0000, 32'h080, 32'h0, 99, 32'h0);
    do_access("lw_ack_last", 1'b0, 1'b1, 3'b010, 4'b0000, 32'h084, 32'h0, TIMEOUT - 1, 32'h55AA55AA);
  endtask

  task automatic test_ack_outside_req();
    do_access("lbu_pre", 1'b0, 1'b1, 3'b100, 4'b0000, 32'h002, 32'h0, 0, 32'h00800000);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    tests_run++;
    if ({dmem_req, mem_errM, ld_dataM} !== {2'b00, 32'h00000080}) begin
      tests_failed++;
      $display("FAIL stray_ack: req/err/ld got %h expected %h", {dmem_req, mem_errM, ld_dataM}, {2'b00, 32'h00000080});
    end
  endtask

  task automatic test_reset_mid_req();
    mem_wrenM = 1'b0; wb_selM = 2'b01; ld_selM = 3'b010; alu_dataM = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_req_pre: req got %b expected 1", dmem_req);
    end
    idle_inputs(); aclr = 1'b0; #1;
    tests_run++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ld_dataM, mem_errM, stallM} !== 83'd0) begin
      tests_failed++;
      $display("FAIL mid_req_reset: got %h expected 0",
               {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ld_dataM, mem_errM, stallM});
    end
    @(posedge clk); #1; aclr = 1'b1;
    @(posedge clk); #1;
    do_access("lw_after_reset", 1'b0, 1'b1, 3'b010, 4'b0000, 32'h208, 32'h0, 1, 32'h12345678);
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] ldsels [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [3:0] bes    [3] = '{4'b0001, 4'b0011, 4'b1111};
    bit wr, ld;
    int ack_at;
    for (int i = 0; i < 40; i++) begin
      wr     = bit'($urandom_range(0, 1));
      ld     = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      ack_at = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 3));
      do_access("random", wr, ld, ldsels[$urandom_range(0, 4)], bes[$urandom_range(0, 2)],
                $urandom, $urandom, ack_at, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_spec_examples();
    test_extension();
    test_timeout();
    test_ack_outside_req();
    test_reset_mid_req();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
